// File: rtl/ifetch_handshake.sv
// Instruction-fetch stage: owns the PC, fetches over a req/valid handshake, and picks the next PC at retire.
// Optional IFETCH_PERF_CNT_EN adds fetch_count/stall_count performance counters.
module ifetch_handshake #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 14
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_valid,
  output logic [31:0]        Instruction,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        opcplus4,
  input  logic [31:0]        Addr_result,
  input  logic [31:0]        Read_data_1,
  input  logic               Branch,
  input  logic               nBranch,
  input  logic               Jmp,
  input  logic               Jal,
  input  logic               Jr,
  input  logic               Zero,
  output logic               pc_misaligned
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_req;
  logic        r_misaligned;

  logic [31:0] w_opcplus4;
  logic [31:0] w_next_pc;
  logic        w_target_misaligned;
  logic        w_branch_taken;
  logic        w_retire;

  assign w_opcplus4     = r_pc + 32'd4;
  assign w_branch_taken = (Branch & Zero) | (nBranch & ~Zero);
  assign w_retire       = (r_state == S_HOLD) && inst_ready;

  // Only Jr and branch targets can arrive misaligned; jump targets are built word-aligned.
  always_comb begin
    w_next_pc           = w_opcplus4;
    w_target_misaligned = 1'b0;
    if (Jr) begin
      w_next_pc           = {Read_data_1[31:2], 2'b00};
      w_target_misaligned = |Read_data_1[1:0];
    end else if (Jmp | Jal) begin
      w_next_pc = {w_opcplus4[31:28], r_instr[25:0], 2'b00};
    end else if (w_branch_taken) begin
      w_next_pc           = {Addr_result[31:2], 2'b00};
      w_target_misaligned = |Addr_result[1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_instr      <= '0;
      r_req        <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
        end
        S_REQ: begin
          if (imem_valid) begin
            r_instr <= imem_rdata;
            r_req   <= 1'b0;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            r_pc    <= w_next_pc;
            r_req   <= 1'b1;
            r_state <= S_REQ;
            if (w_target_misaligned) r_misaligned <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req      = r_req;
  assign imem_addr     = r_pc[IMEM_AW+1:2];
  assign Instruction   = r_instr;
  assign inst_valid    = (r_state == S_HOLD);
  assign opcplus4      = w_opcplus4;
  assign pc_misaligned = r_misaligned;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;
  logic        w_stall;

  assign w_stall = ((r_state == S_REQ) && !imem_valid) || ((r_state == S_HOLD) && !inst_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_retire) r_fetch_count <= r_fetch_count + 32'd1;
      if (w_stall)  r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`else
  logic w_retire_unused;
  assign w_retire_unused = w_retire;
`endif

endmodule

// File: tb/tb_ifetch_handshake.sv
// Directed bench for ifetch_handshake: vector table for the fetch/next-PC flow plus wait-state and reset sequences.
module tb_ifetch_handshake;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic        inst_ready = 1'b0;
  logic [31:0] Addr_result = '0;
  logic [31:0] Read_data_1 = '0;
  logic        Branch = 1'b0, nBranch = 1'b0, Jmp = 1'b0, Jal = 1'b0, Jr = 1'b0, Zero = 1'b0;

  logic        imem_req, inst_valid, pc_misaligned;
  logic [13:0] imem_addr;
  logic [31:0] Instruction, opcplus4;
  logic        imem_req2, inst_valid2, pc_misaligned2;
  logic [13:0] imem_addr2;
  logic [31:0] Instruction2, opcplus42;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count, fetch_count2, stall_count2;
`endif

  always #5 clock = ~clock;

  ifetch_handshake #(.RESET_PC(32'h0000_0000), .IMEM_AW(14)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .Instruction(Instruction),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .opcplus4(opcplus4),
    .Addr_result(Addr_result), .Read_data_1(Read_data_1), .Branch(Branch),
    .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr), .Zero(Zero),
    .pc_misaligned(pc_misaligned)
`ifdef IFETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  ifetch_handshake #(.RESET_PC(32'hFFFF_FFFC), .IMEM_AW(14)) dut_top (
    .clock(clock), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .Instruction(Instruction2),
    .inst_valid(inst_valid2), .inst_ready(inst_ready), .opcplus4(opcplus42),
    .Addr_result(Addr_result), .Read_data_1(Read_data_1), .Branch(Branch),
    .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr), .Zero(Zero),
    .pc_misaligned(pc_misaligned2)
`ifdef IFETCH_PERF_CNT_EN
    , .fetch_count(fetch_count2), .stall_count(stall_count2)
`endif
  );

  typedef struct {
    logic        valid;
    logic [31:0] rdata;
    logic        ready;
    logic [4:0]  ctl;    // {Jr, Jmp, Jal, Branch, nBranch}
    logic        zero;
    logic [31:0] ares;
    logic [31:0] rd1;
    logic        e_req;
    logic [13:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_op4;
    logic        e_mis;
  } vec_t;

  localparam logic [4:0] C_NONE = 5'b00000, C_JR = 5'b10000, C_JAL = 5'b00100,
                         C_BR = 5'b00010, C_NBR = 5'b00001;

  int unsigned checks = 0;
  int unsigned errors = 0;
  vec_t vecs[21];

  function automatic vec_t mk(input logic v, input logic [31:0] rd, input logic rdy,
                              input logic [4:0] c, input logic z, input logic [31:0] ar,
                              input logic [31:0] r1, input logic req, input logic [13:0] ad,
                              input logic iv, input logic [31:0] ins, input logic [31:0] op4,
                              input logic mis);
    vec_t t;
    t.valid = v; t.rdata = rd; t.ready = rdy; t.ctl = c; t.zero = z; t.ares = ar; t.rd1 = r1;
    t.e_req = req; t.e_addr = ad; t.e_iv = iv; t.e_instr = ins; t.e_op4 = op4; t.e_mis = mis;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    imem_valid = t.valid; imem_rdata = t.rdata; inst_ready = t.ready;
    {Jr, Jmp, Jal, Branch, nBranch} = t.ctl;
    Zero = t.zero; Addr_result = t.ares; Read_data_1 = t.rd1;
  endtask

  task automatic idle_inputs();
    imem_valid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    {Jr, Jmp, Jal, Branch, nBranch} = 5'b0;
    Zero = 1'b0; Addr_result = '0; Read_data_1 = '0;
  endtask

  initial begin
    int unsigned req_cycles;
    //          v  rdata          rdy ctl     z  ares        rd1         req addr    iv instr          op4          mis
    vecs[0]  = mk(0, 32'h0,        0, C_NONE, 0, 32'h0,     32'h0,      1, 14'h000, 0, 32'h0,        32'h4,       0);
    vecs[1]  = mk(1, 32'h1111_1111,0, C_NONE, 0, 32'h0,     32'h0,      0, 14'h000, 1, 32'h1111_1111,32'h4,       0);
    vecs[2]  = mk(0, 32'h0,        1, C_NONE, 0, 32'h0,     32'h0,      1, 14'h001, 0, 32'h1111_1111,32'h8,       0);
    vecs[3]  = mk(1, 32'h2222_2222,0, C_NONE, 0, 32'h0,     32'h0,      0, 14'h001, 1, 32'h2222_2222,32'h8,       0);
    vecs[4]  = mk(0, 32'h0,        1, C_NONE, 0, 32'h0,     32'h0,      1, 14'h002, 0, 32'h2222_2222,32'hC,       0);
    vecs[5]  = mk(1, 32'h0C00_0020,0, C_NONE, 0, 32'h0,     32'h0,      0, 14'h002, 1, 32'h0C00_0020,32'hC,       0);
    vecs[6]  = mk(0, 32'h0,        1, C_JAL,  0, 32'h0,     32'h0,      1, 14'h020, 0, 32'h0C00_0020,32'h84,      0);
    vecs[7]  = mk(1, 32'h03E0_0008,0, C_NONE, 0, 32'h0,     32'h0,      0, 14'h020, 1, 32'h03E0_0008,32'h84,      0);
    vecs[8]  = mk(0, 32'h0,        1, C_JR,   0, 32'h0,     32'hC,      1, 14'h003, 0, 32'h03E0_0008,32'h10,      0);
    vecs[9]  = mk(1, 32'h3333_3333,0, C_NONE, 0, 32'h0,     32'h0,      0, 14'h003, 1, 32'h3333_3333,32'h10,      0);
    vecs[10] = mk(0, 32'h0,        1, C_NONE, 0, 32'h0,     32'h0,      1, 14'h004, 0, 32'h3333_3333,32'h14,      0);
    vecs[11] = mk(1, 32'h1000_0000,0, C_NONE, 0, 32'h0,     32'h0,      0, 14'h004, 1, 32'h1000_0000,32'h14,      0);
    vecs[12] = mk(0, 32'h0,        1, C_BR,   1, 32'h40,    32'h0,      1, 14'h010, 0, 32'h1000_0000,32'h44,      0);
    vecs[13] = mk(1, 32'h1000_0000,0, C_NONE, 0, 32'h0,     32'h0,      0, 14'h010, 1, 32'h1000_0000,32'h44,      0);
    vecs[14] = mk(0, 32'h0,        1, C_BR,   0, 32'h80,    32'h0,      1, 14'h011, 0, 32'h1000_0000,32'h48,      0);
    vecs[15] = mk(1, 32'h1400_0000,0, C_NONE, 0, 32'h0,     32'h0,      0, 14'h011, 1, 32'h1400_0000,32'h48,      0);
    vecs[16] = mk(0, 32'h0,        1, C_NBR,  0, 32'h200,   32'h0,      1, 14'h080, 0, 32'h1400_0000,32'h204,     0);
    vecs[17] = mk(0, 32'h0,        1, C_JR,   0, 32'h0,     32'h500,    1, 14'h080, 0, 32'h1400_0000,32'h204,     0);
    vecs[18] = mk(1, 32'h4444_4444,0, C_NONE, 0, 32'h0,     32'h0,      0, 14'h080, 1, 32'h4444_4444,32'h204,     0);
    vecs[19] = mk(1, 32'hDEAD_BEEF,0, C_JR,   0, 32'h0,     32'h3,      0, 14'h080, 1, 32'h4444_4444,32'h204,     0);
    vecs[20] = mk(0, 32'h0,        1, C_JR,   0, 32'h0,     32'h102,    1, 14'h040, 0, 32'h4444_4444,32'h104,     1);

    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req",   32'(imem_req),      32'h0);
    chk("rst_iv",    32'(inst_valid),    32'h0);
    chk("rst_instr", Instruction,        32'h0);
    chk("rst_mis",   32'(pc_misaligned), 32'h0);
    chk("rst_op4",   opcplus4,           32'h4);
    chk("rst_addr",  32'(imem_addr),     32'h0);
    chk("top_rst_op4",  opcplus42,        32'h0);
    chk("top_rst_addr", 32'(imem_addr2),  32'h3FFF);

    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 21; i++) begin
      if (i > 0) @(negedge clock);
      drive(vecs[i]);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_req", i),   32'(imem_req),      32'(vecs[i].e_req));
      chk($sformatf("v%0d_addr", i),  32'(imem_addr),     32'(vecs[i].e_addr));
      chk($sformatf("v%0d_iv", i),    32'(inst_valid),    32'(vecs[i].e_iv));
      chk($sformatf("v%0d_instr", i), Instruction,        vecs[i].e_instr);
      chk($sformatf("v%0d_op4", i),   opcplus4,           vecs[i].e_op4);
      chk($sformatf("v%0d_mis", i),   32'(pc_misaligned), 32'(vecs[i].e_mis));
      if (i == 2) begin
        chk("top_wrap_addr", 32'(imem_addr2), 32'h0);
        chk("top_wrap_op4",  opcplus42,       32'h4);
      end
    end

    // Asynchronous reset during REQ with misaligned flag set
    @(negedge clock);
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_req",  32'(imem_req),      32'h0);
    chk("mid_rst_mis",  32'(pc_misaligned), 32'h0);
    chk("mid_rst_op4",  opcplus4,           32'h4);
    chk("mid_rst_addr", 32'(imem_addr),     32'h0);
    chk("mid_rst_iv",   32'(inst_valid),    32'h0);

    // Three memory wait cycles, then retire held off for two cycles
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    req_cycles = 0;
    @(posedge clock); #1;
    if (imem_req) req_cycles++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); imem_valid = 1'b0;
      @(posedge clock); #1;
      if (imem_req) req_cycles++;
      chk($sformatf("wait%0d_iv", k), 32'(inst_valid), 32'h0);
    end
    @(negedge clock); imem_valid = 1'b1; imem_rdata = 32'h55AA_55AA;
    @(posedge clock); #1;
    if (imem_req) req_cycles++;
    chk("req_cycles", req_cycles, 32'd4);
    chk("wfetch_iv", 32'(inst_valid), 32'h1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock); imem_valid = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
      @(posedge clock); #1;
      chk($sformatf("hold%0d_instr", k), Instruction,     32'h55AA_55AA);
      chk($sformatf("hold%0d_iv", k),    32'(inst_valid), 32'h1);
    end
    @(negedge clock); inst_ready = 1'b1;
    @(posedge clock); #1;
    chk("wret_iv",   32'(inst_valid), 32'h0);
    chk("wret_req",  32'(imem_req),   32'h1);
    chk("wret_addr", 32'(imem_addr),  32'h1);
`ifdef IFETCH_PERF_CNT_EN
    chk("stall_count", stall_count, 32'd5);
    chk("fetch_count", fetch_count, 32'd1);
`endif
    @(negedge clock);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
